// File: rtl/cam_capture_if.sv
// Bundles the parallel camera pins and the pixel/marker outputs of cam_capture.
// Handshake: pix_valid, frame_start, frame_end and line_end are one-cycle strobes
// with no ready/backpressure; pix_data/pix_x/pix_y hold until the next pix_valid.
interface cam_capture_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  logic          apclk;
  logic          ahref;
  logic          avsync;
  logic [7:0]    adata;
  logic          err_clr;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          frame_start;
  logic          frame_end;
  logic          line_end;
  logic          odd_err;
  logic          overrun_err;

  modport master (
    output apclk, ahref, avsync, adata, err_clr,
    input  pix_valid, pix_data, pix_x, pix_y,
    input  frame_start, frame_end, line_end, odd_err, overrun_err
  );

  modport slave (
    input  apclk, ahref, avsync, adata, err_clr,
    output pix_valid, pix_data, pix_x, pix_y,
    output frame_start, frame_end, line_end, odd_err, overrun_err
  );
endinterface

// File: rtl/cam_capture.sv
// Camera bus receiver: oversamples apclk/ahref/avsync/adata in the inclk domain,
// pairs bytes into 16-bit pixels tagged with x/y, and emits frame/line markers.
module cam_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int XW       = 10,
  parameter int YW       = 9,
  parameter bit HI_FIRST = 1'b1
) (
  input  logic         inclk,
  input  logic         res,
  cam_capture_if.slave bus,
  output logic [1:0]   state_dbg
);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ARMED   = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam logic [XW-1:0] X_LIM = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_LIM = YW'(V_ACTIVE);

  logic [2:0]    pclk_sh_q, pclk_sh_d;
  logic [1:0]    href_sh_q, href_sh_d;
  logic [1:0]    vsync_sh_q, vsync_sh_d;
  logic [7:0]    data_s1_q, data_s1_d;
  logic [7:0]    data_s2_q, data_s2_d;
  state_t        state_q, state_d;
  logic          phase_q, phase_d;
  logic [7:0]    byte_q, byte_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          line_got_q, line_got_d;
  logic          href_prev_q, href_prev_d;
  logic          pix_valid_q, pix_valid_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic [XW-1:0] pix_x_q, pix_x_d;
  logic [YW-1:0] pix_y_q, pix_y_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_end_q, frame_end_d;
  logic          line_end_q, line_end_d;
  logic          odd_err_q, odd_err_d;
  logic          overrun_err_q, overrun_err_d;

  logic samp_e;
  logic href_s2;
  logic vsync_s2;

  // Index 1 of each shift register is the second synchronizer stage (s2).
  assign samp_e   = pclk_sh_q[1] & ~pclk_sh_q[2];
  assign href_s2  = href_sh_q[1];
  assign vsync_s2 = vsync_sh_q[1];

  always_comb begin
    pclk_sh_d     = {pclk_sh_q[1:0], bus.apclk};
    href_sh_d     = {href_sh_q[0], bus.ahref};
    vsync_sh_d    = {vsync_sh_q[0], bus.avsync};
    data_s1_d     = bus.adata;
    data_s2_d     = data_s1_q;
    state_d       = state_q;
    phase_d       = phase_q;
    byte_d        = byte_q;
    x_d           = x_q;
    y_d           = y_q;
    line_got_d    = line_got_q;
    href_prev_d   = href_prev_q;
    pix_valid_d   = 1'b0;
    pix_data_d    = pix_data_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    line_end_d    = 1'b0;
    odd_err_d     = odd_err_q;
    overrun_err_d = overrun_err_q;

    // Clear is applied first so a same-cycle error set below overrides it.
    if (bus.err_clr) begin
      odd_err_d     = 1'b0;
      overrun_err_d = 1'b0;
    end

    if (samp_e) begin
      href_prev_d = href_s2;
      unique case (state_q)
        WAIT_VS: begin
          if (vsync_s2) state_d = ARMED;
        end
        ARMED: begin
          if (!vsync_s2) begin
            state_d       = ACTIVE;
            frame_start_d = 1'b1;
            x_d           = '0;
            y_d           = '0;
            phase_d       = 1'b0;
            line_got_d    = 1'b0;
          end
        end
        ACTIVE: begin
          if (vsync_s2) begin
            state_d     = ARMED;
            frame_end_d = 1'b1;
            x_d         = '0;
            phase_d     = 1'b0;
            line_got_d  = 1'b0;
          end else if (href_s2) begin
            line_got_d = 1'b1;
            if (!phase_q) begin
              byte_d  = data_s2_q;
              phase_d = 1'b1;
            end else begin
              phase_d = 1'b0;
              // Past the active window the pair is discarded, counters hold.
              if (x_q == X_LIM || y_q == Y_LIM) begin
                overrun_err_d = 1'b1;
              end else begin
                pix_valid_d = 1'b1;
                pix_data_d  = HI_FIRST ? {byte_q, data_s2_q} : {data_s2_q, byte_q};
                pix_x_d     = x_q;
                pix_y_d     = y_q;
                x_d         = x_q + XW'(1);
              end
            end
          end else if (href_prev_q) begin
            line_end_d = 1'b1;
            if (phase_q) odd_err_d = 1'b1;
            x_d        = '0;
            phase_d    = 1'b0;
            line_got_d = 1'b0;
            if (line_got_q && y_q != Y_LIM) y_d = y_q + YW'(1);
          end
        end
        default: state_d = WAIT_VS;
      endcase
    end
  end

  always_ff @(posedge inclk or posedge res) begin
    if (res) begin
      pclk_sh_q     <= '0;
      href_sh_q     <= '0;
      vsync_sh_q    <= '0;
      data_s1_q     <= '0;
      data_s2_q     <= '0;
      state_q       <= WAIT_VS;
      phase_q       <= 1'b0;
      byte_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      line_got_q    <= 1'b0;
      href_prev_q   <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
      line_end_q    <= 1'b0;
      odd_err_q     <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      pclk_sh_q     <= pclk_sh_d;
      href_sh_q     <= href_sh_d;
      vsync_sh_q    <= vsync_sh_d;
      data_s1_q     <= data_s1_d;
      data_s2_q     <= data_s2_d;
      state_q       <= state_d;
      phase_q       <= phase_d;
      byte_q        <= byte_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_got_q    <= line_got_d;
      href_prev_q   <= href_prev_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
      line_end_q    <= line_end_d;
      odd_err_q     <= odd_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  assign bus.pix_valid   = pix_valid_q;
  assign bus.pix_data    = pix_data_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.line_end    = line_end_q;
  assign bus.odd_err     = odd_err_q;
  assign bus.overrun_err = overrun_err_q;
  assign state_dbg       = state_q;

endmodule
